// File: rtl/flash_load_seq.sv
// rtl/flash_load_seq.sv - flash erase/load/program/readback sequencer with checksum compare
module flash_load_seq #(
    parameter int          NBYTES     = 448,
    parameter logic [23:0] ERASE_WAIT = 24'd2000000,
    parameter logic [23:0] PRG_WAIT   = 24'd500000,
    parameter logic [15:0] DTACK_TMO  = 16'd1024
) (
    input  logic        FASTCLK,
    input  logic        RST_B,
    input  logic        START,
    input  logic        ABORT,
    input  logic [7:0]  SRC_DATA,
    input  logic        SRC_VLD,
    output logic        SRC_RDY,
    output logic        DEVICE,
    output logic [9:0]  COMMAND,
    output logic        STROBE,
    output logic        WRITE_B,
    output logic [15:0] INDATA,
    input  logic        DTACK_B,
    input  logic [15:0] OUTDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [1:0]  ERRCODE,
    output logic [15:0] CHK_WR,
    output logic [15:0] CHK_RD
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_INIT   = 4'd1;
    localparam logic [3:0] S_ERASE  = 4'd2;
    localparam logic [3:0] S_ERWAIT = 4'd3;
    localparam logic [3:0] S_LOAD   = 4'd4;
    localparam logic [3:0] S_PROG   = 4'd5;
    localparam logic [3:0] S_PRWAIT = 4'd6;
    localparam logic [3:0] S_INIT2  = 4'd7;
    localparam logic [3:0] S_READ   = 4'd8;
    localparam logic [3:0] S_CHECK  = 4'd9;

    // Handshake phase inside a command state; HS_SRC/HS_POP only occur in LOAD.
    localparam logic [2:0] HS_NONE = 3'd0;
    localparam logic [2:0] HS_SRC  = 3'd1;
    localparam logic [2:0] HS_POP  = 3'd2;
    localparam logic [2:0] HS_SET  = 3'd3;
    localparam logic [2:0] HS_STB  = 3'd4;
    localparam logic [2:0] HS_REL  = 3'd5;

    localparam logic [9:0]  BYTE_LAST = 10'(NBYTES - 1);
    localparam logic [23:0] ER_LAST   = ERASE_WAIT - 24'd1;
    localparam logic [23:0] PR_LAST   = PRG_WAIT - 24'd1;
    localparam logic [15:0] TMO_LAST  = DTACK_TMO - 16'd1;

    logic [3:0]  state;
    logic [2:0]  hs;
    logic [9:0]  bcnt;
    logic [23:0] wcnt;
    logic [15:0] tcnt;
    logic [7:0]  byte_q;
    logic        abort_pend;
    logic        abort_now;
    logic        ack;
    logic        unused_outdata_hi;

    // Only a clean 0 acknowledges; X/Z fall into the else branches as a 1 would.
    assign ack               = (DTACK_B == 1'b0);
    assign abort_now         = ABORT | abort_pend;
    assign unused_outdata_hi = ^OUTDATA[15:8];

    assign BUSY    = (state != S_IDLE);
    assign STROBE  = (hs == HS_STB);
    assign DEVICE  = (hs == HS_SET) || (hs == HS_STB);
    assign SRC_RDY = (hs == HS_POP);
    assign WRITE_B = (state != S_READ);
    assign INDATA  = (state == S_LOAD) ? {8'h00, byte_q} : 16'h0000;

    always_comb begin
        COMMAND = 10'd0;
        case (state)
            S_ERASE: COMMAND = 10'd5;
            S_LOAD:  COMMAND = 10'd1;
            S_PROG:  COMMAND = 10'd2;
            S_READ:  COMMAND = 10'd6;
            default: COMMAND = 10'd0;
        endcase
    end

    always_ff @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
            state      <= S_IDLE;
            hs         <= HS_NONE;
            bcnt       <= 10'd0;
            wcnt       <= 24'd0;
            tcnt       <= 16'd0;
            byte_q     <= 8'h00;
            abort_pend <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            ERRCODE    <= 2'b00;
            CHK_WR     <= 16'h0000;
            CHK_RD     <= 16'h0000;
        end else begin
            if (state != S_IDLE && ABORT) begin
                abort_pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    abort_pend <= 1'b0;
                    if (START && !ABORT) begin
                        DONE    <= 1'b0;
                        ERR     <= 1'b0;
                        ERRCODE <= 2'b00;
                        CHK_WR  <= 16'h0000;
                        CHK_RD  <= 16'h0000;
                        bcnt    <= 10'd0;
                        wcnt    <= 24'd0;
                        tcnt    <= 16'd0;
                        state   <= S_INIT;
                        hs      <= HS_SET;
                    end
                end
                S_ERWAIT, S_PRWAIT: begin
                    if (abort_now) begin
                        state <= S_IDLE;
                        hs    <= HS_NONE;
                    end else if (wcnt == ((state == S_ERWAIT) ? ER_LAST : PR_LAST)) begin
                        wcnt  <= 24'd0;
                        state <= (state == S_ERWAIT) ? S_LOAD : S_INIT2;
                        hs    <= (state == S_ERWAIT) ? HS_SRC : HS_SET;
                    end else begin
                        wcnt <= wcnt + 24'd1;
                    end
                end
                S_CHECK: begin
                    state <= S_IDLE;
                    hs    <= HS_NONE;
                    if (!abort_now) begin
                        if (CHK_RD == CHK_WR) begin
                            DONE <= 1'b1;
                        end else begin
                            ERR     <= 1'b1;
                            ERRCODE <= 2'b10;
                        end
                    end
                end
                default: begin
                    case (hs)
                        HS_SRC: begin
                            if (abort_now) begin
                                state <= S_IDLE;
                                hs    <= HS_NONE;
                            end else if (SRC_VLD) begin
                                hs <= HS_POP;
                            end
                        end
                        HS_POP: begin
                            if (SRC_VLD) begin
                                byte_q <= SRC_DATA;
                                CHK_WR <= CHK_WR + {8'h00, SRC_DATA};
                                hs     <= HS_SET;
                            end else begin
                                hs <= HS_SRC;
                            end
                        end
                        HS_SET: begin
                            tcnt <= 16'd0;
                            hs   <= HS_STB;
                        end
                        HS_STB: begin
                            if (ack) begin
                                tcnt <= 16'd0;
                                hs   <= HS_REL;
                                if (state == S_READ) begin
                                    CHK_RD <= CHK_RD + {8'h00, OUTDATA[7:0]};
                                end
                            end else if (tcnt == TMO_LAST) begin
                                ERR     <= 1'b1;
                                ERRCODE <= 2'b01;
                                state   <= S_IDLE;
                                hs      <= HS_NONE;
                            end else begin
                                tcnt <= tcnt + 16'd1;
                            end
                        end
                        HS_REL: begin
                            if (ack) begin
                                if (tcnt == TMO_LAST) begin
                                    ERR     <= 1'b1;
                                    ERRCODE <= 2'b01;
                                    state   <= S_IDLE;
                                    hs      <= HS_NONE;
                                end else begin
                                    tcnt <= tcnt + 16'd1;
                                end
                            end else if (abort_now) begin
                                state <= S_IDLE;
                                hs    <= HS_NONE;
                            end else begin
                                // Handshake finished: pick the next command or wait state.
                                case (state)
                                    S_INIT: begin
                                        state <= S_ERASE;
                                        hs    <= HS_SET;
                                    end
                                    S_ERASE: begin
                                        wcnt  <= 24'd0;
                                        state <= S_ERWAIT;
                                        hs    <= HS_NONE;
                                    end
                                    S_LOAD: begin
                                        if (bcnt == BYTE_LAST) begin
                                            bcnt  <= 10'd0;
                                            state <= S_PROG;
                                            hs    <= HS_SET;
                                        end else begin
                                            bcnt <= bcnt + 10'd1;
                                            hs   <= HS_SRC;
                                        end
                                    end
                                    S_PROG: begin
                                        wcnt  <= 24'd0;
                                        state <= S_PRWAIT;
                                        hs    <= HS_NONE;
                                    end
                                    S_INIT2: begin
                                        bcnt  <= 10'd0;
                                        state <= S_READ;
                                        hs    <= HS_SET;
                                    end
                                    S_READ: begin
                                        if (bcnt == BYTE_LAST) begin
                                            bcnt  <= 10'd0;
                                            state <= S_CHECK;
                                            hs    <= HS_NONE;
                                        end else begin
                                            bcnt <= bcnt + 10'd1;
                                            hs   <= HS_SET;
                                        end
                                    end
                                    default: begin
                                        state <= S_IDLE;
                                        hs    <= HS_NONE;
                                    end
                                endcase
                            end
                        end
                        default: begin
                            state <= S_IDLE;
                            hs    <= HS_NONE;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_load_seq.sv
// tb/tb_flash_load_seq.sv - self-checking bench for flash_load_seq with flash/DTACK and source models
module tb_flash_load_seq;

    logic        FASTCLK = 1'b0;
    logic        RST_B   = 1'b1;
    logic        START   = 1'b0;
    logic        ABORT   = 1'b0;
    logic [7:0]  SRC_DATA = 8'h00;
    logic        SRC_VLD  = 1'b0;
    logic        SRC_RDY;
    logic        DEVICE;
    logic [9:0]  COMMAND;
    logic        STROBE;
    logic        WRITE_B;
    logic [15:0] INDATA;
    logic        DTACK_B = 1'b1;
    logic [15:0] OUTDATA = 16'h0000;
    logic        BUSY, DONE, ERR;
    logic [1:0]  ERRCODE;
    logic [15:0] CHK_WR, CHK_RD;

    always #5 FASTCLK = ~FASTCLK;

    flash_load_seq #(
        .NBYTES(4), .ERASE_WAIT(24'd8), .PRG_WAIT(24'd8), .DTACK_TMO(16'd16)
    ) dut (
        .FASTCLK(FASTCLK), .RST_B(RST_B), .START(START), .ABORT(ABORT),
        .SRC_DATA(SRC_DATA), .SRC_VLD(SRC_VLD), .SRC_RDY(SRC_RDY),
        .DEVICE(DEVICE), .COMMAND(COMMAND), .STROBE(STROBE), .WRITE_B(WRITE_B),
        .INDATA(INDATA), .DTACK_B(DTACK_B), .OUTDATA(OUTDATA),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERRCODE(ERRCODE),
        .CHK_WR(CHK_WR), .CHK_RD(CHK_RD)
    );

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] rd;
        logic [7:0]  dly;
        logic [15:0] e_wr;
        logic [15:0] e_rd;
        logic        e_done;
        logic        e_err;
        logic [1:0]  e_code;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] src_bytes [4];
    logic [7:0] rd_bytes  [4];
    logic [9:0] exp_cmds  [12];
    logic [9:0] cmds [$];
    int   ack_delay = 3;
    logic [9:0] nack_cmd = 10'h3FF;
    bit   src_en = 1'b1;
    int   src_idx = 0, rd_idx = 0, load_idx = 0, stb_cnt = 0, pops = 0;
    bit   pend = 1'b0, prev_stb = 1'b0;
    int   wb_errs = 0, indata_errs = 0, inv_errs = 0, last_stb_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Flash controller and host source model, updated just after each rising edge.
    always @(posedge FASTCLK) begin
        logic [15:0] exp_in;
        #1;
        if (pend) begin src_idx++; pend = 1'b0; end
        if (SRC_RDY && SRC_VLD) begin pend = 1'b1; pops++; end
        SRC_VLD  = src_en && (src_idx < 4);
        SRC_DATA = (src_idx < 4) ? src_bytes[src_idx] : 8'h00;
        if (DONE && ERR) inv_errs++;
        if (STROBE && !BUSY) inv_errs++;
        if (STROBE) begin
            if (!prev_stb) begin
                cmds.push_back(COMMAND);
                if (WRITE_B !== (COMMAND != 10'd6)) wb_errs++;
                exp_in = (COMMAND == 10'd1 && load_idx < 4) ? {8'h00, src_bytes[load_idx]} : 16'h0000;
                if (INDATA !== exp_in) indata_errs++;
                if (COMMAND == 10'd1) load_idx++;
                if (COMMAND == 10'd0) rd_idx = 0;
                stb_cnt = 0;
            end
            stb_cnt++;
            if (COMMAND != nack_cmd && stb_cnt >= ack_delay && DTACK_B) begin
                DTACK_B = 1'b0;
                if (COMMAND == 10'd6) begin
                    OUTDATA = {8'h00, (rd_idx < 4) ? rd_bytes[rd_idx] : 8'h00};
                    rd_idx++;
                end
            end
        end else begin
            if (prev_stb) last_stb_len = stb_cnt;
            DTACK_B = 1'b1;
        end
        prev_stb = STROBE;
    end

    task automatic prep(input logic [31:0] b, input logic [31:0] r, input int dly);
        for (int i = 0; i < 4; i++) begin
            src_bytes[i] = b[8*i +: 8];
            rd_bytes[i]  = r[8*i +: 8];
        end
        ack_delay = dly;
        src_idx = 0; rd_idx = 0; load_idx = 0; pops = 0; pend = 1'b0;
        cmds.delete();
    endtask

    task automatic do_run(input logic [31:0] b, input logic [31:0] r, input int dly,
                          input int extra_at, input int stall_until, input int abort_cmd,
                          input int budget, output bit finished, output int stall_viol);
        bit ab_done = 1'b0;
        prep(b, r, dly);
        src_en = (stall_until == 0);
        stall_viol = 0;
        finished = 1'b0;
        @(negedge FASTCLK) START = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge FASTCLK);
            START = (i == extra_at);
            if (stall_until > 0) begin
                src_en = (i >= stall_until);
                if (i >= 100 && i < stall_until && (SRC_RDY || STROBE || DEVICE || ERR)) stall_viol++;
            end
            ABORT = (abort_cmd > 0) && (cmds.size() == abort_cmd) && STROBE && !ab_done;
            if (ABORT) ab_done = 1'b1;
            if (!BUSY && !START && !ABORT) begin finished = 1'b1; break; end
        end
        START = 1'b0;
        ABORT = 1'b0;
        src_en = 1'b1;
    endtask

    task automatic check_full(input string p, input bit fin, input logic [15:0] e_wr,
                              input logic [15:0] e_rd, input logic e_done, input logic e_err,
                              input logic [1:0] e_code);
        int mism = 0;
        check({p, "_finished"}, fin, 1);
        check({p, "_chk_wr"}, CHK_WR, e_wr);
        check({p, "_chk_rd"}, CHK_RD, e_rd);
        check({p, "_done"}, DONE, e_done);
        check({p, "_err"}, ERR, e_err);
        check({p, "_errcode"}, ERRCODE, e_code);
        check({p, "_ncmd"}, cmds.size(), 12);
        for (int i = 0; i < 12 && i < cmds.size(); i++) if (cmds[i] != exp_cmds[i]) mism++;
        check({p, "_cmd_order"}, mism, 0);
        check({p, "_pops"}, pops, 4);
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_strobe"}, STROBE, 0);
        check({p, "_device"}, DEVICE, 0);
        check({p, "_write_b"}, WRITE_B, 1);
        check({p, "_command"}, COMMAND, 0);
        check({p, "_indata"}, INDATA, 0);
        check({p, "_src_rdy"}, SRC_RDY, 0);
        check({p, "_busy"}, BUSY, 0);
        check({p, "_done"}, DONE, 0);
        check({p, "_err"}, ERR, 0);
        check({p, "_errcode"}, ERRCODE, 0);
        check({p, "_chk_wr"}, CHK_WR, 0);
        check({p, "_chk_rd"}, CHK_RD, 0);
    endtask

    initial begin
        vec_t vecs [5];
        bit   fin;
        int   sv;
        logic [31:0] b, r;
        logic [15:0] m_wr, m_rd;
        bit   hit;

        exp_cmds = '{10'd0, 10'd5, 10'd1, 10'd1, 10'd1, 10'd1, 10'd2, 10'd0, 10'd6, 10'd6, 10'd6, 10'd6};
        vecs[0] = '{32'h04030201, 32'h04030201, 8'd3, 16'h000A, 16'h000A, 1'b1, 1'b0, 2'b00};
        vecs[1] = '{32'h04030201, 32'h04FF0201, 8'd3, 16'h000A, 16'h0106, 1'b0, 1'b1, 2'b10};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'd1, 16'h03FC, 16'h03FC, 1'b1, 1'b0, 2'b00};
        vecs[3] = '{32'h40302010, 32'h40302011, 8'd5, 16'h00A0, 16'h00A1, 1'b0, 1'b1, 2'b10};
        vecs[4] = '{32'h80808080, 32'h00000000, 8'd2, 16'h0200, 16'h0000, 1'b0, 1'b1, 2'b10};

        #2 RST_B = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge FASTCLK);
        RST_B = 1'b1;

        for (int k = 0; k < 5; k++) begin
            do_run(vecs[k].src, vecs[k].rd, int'(vecs[k].dly), -1, 0, 0, 400, fin, sv);
            check_full($sformatf("row%0d", k), fin, vecs[k].e_wr, vecs[k].e_rd,
                       vecs[k].e_done, vecs[k].e_err, vecs[k].e_code);
        end

        // Randomized runs against a sum-based reference.
        for (int k = 0; k < 8; k++) begin
            b = $urandom;
            r = $urandom_range(0, 1) ? b : (b ^ (32'h1 << $urandom_range(0, 31)));
            m_wr = 16'h0; m_rd = 16'h0;
            for (int i = 0; i < 4; i++) begin
                m_wr += {8'h00, b[8*i +: 8]};
                m_rd += {8'h00, r[8*i +: 8]};
            end
            do_run(b, r, $urandom_range(1, 12), -1, 0, 0, 400, fin, sv);
            check_full($sformatf("rnd%0d", k), fin, m_wr, m_rd, m_wr == m_rd, m_wr != m_rd,
                       (m_wr == m_rd) ? 2'b00 : 2'b10);
        end

        // Spurious START mid-run is ignored.
        do_run(32'h04030201, 32'h04030201, 3, 30, 0, 0, 400, fin, sv);
        check_full("start_busy", fin, 16'h000A, 16'h000A, 1'b1, 1'b0, 2'b00);

        // Stalled source.
        do_run(32'h04030201, 32'h04030201, 3, -1, 530, 0, 1200, fin, sv);
        check("stall_quiet", sv, 0);
        check_full("stall", fin, 16'h000A, 16'h000A, 1'b1, 1'b0, 2'b00);

        // DTACK timeout on Erase.
        nack_cmd = 10'd5;
        do_run(32'h04030201, 32'h04030201, 3, -1, 0, 0, 400, fin, sv);
        check("tmo_finished", fin, 1);
        check("tmo_strobe_len", last_stb_len, 16);
        check("tmo_err", ERR, 1);
        check("tmo_errcode", ERRCODE, 2'b01);
        check("tmo_done", DONE, 0);
        check("tmo_busy", BUSY, 0);
        repeat (50) @(negedge FASTCLK);
        check("tmo_no_more_cmds", cmds.size(), 2);
        nack_cmd = 10'h3FF;

        // ABORT during the second load handshake.
        do_run(32'h04030201, 32'h04030201, 3, -1, 0, 4, 400, fin, sv);
        check("abort_finished", fin, 1);
        check("abort_ncmd", cmds.size(), 4);
        check("abort_acked", last_stb_len, 3);
        check("abort_done", DONE, 0);
        check("abort_err", ERR, 0);
        repeat (30) @(negedge FASTCLK);
        check("abort_no_prog", cmds.size(), 4);

        // START with ABORT in IDLE does not start.
        prep(32'h04030201, 32'h04030201, 3);
        @(negedge FASTCLK) begin START = 1'b1; ABORT = 1'b1; end
        @(negedge FASTCLK) begin START = 1'b0; ABORT = 1'b0; end
        repeat (5) @(negedge FASTCLK);
        check("start_abort_busy", BUSY, 0);
        check("start_abort_ncmd", cmds.size(), 0);

        // Asynchronous reset after a completed run clears status mid-cycle.
        do_run(32'h04030201, 32'h04030201, 3, -1, 0, 0, 400, fin, sv);
        check("pre_rst_done", DONE, 1);
        @(negedge FASTCLK);
        #2 RST_B = 1'b0;
        #1 check_reset_outputs("rst_after_done");
        @(negedge FASTCLK) RST_B = 1'b1;

        // Reset in ERWAIT, then a full run from INIT.
        prep(32'h04030201, 32'h04030201, 3);
        @(negedge FASTCLK) START = 1'b1;
        @(negedge FASTCLK) START = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge FASTCLK);
            if (cmds.size() == 2 && !STROBE) begin hit = 1'b1; break; end
        end
        check("erwait_reached", hit, 1);
        repeat (3) @(negedge FASTCLK);
        check("erwait_busy", BUSY, 1);
        #2 RST_B = 1'b0;
        #1 check_reset_outputs("rst_erwait");
        @(negedge FASTCLK) RST_B = 1'b1;
        do_run(32'h04030201, 32'h04030201, 3, -1, 0, 0, 400, fin, sv);
        check_full("post_rst", fin, 16'h000A, 16'h000A, 1'b1, 1'b0, 2'b00);

        check("inv_done_err_strobe_idle", inv_errs, 0);
        check("write_b_rule", wb_errs, 0);
        check("indata_rule", indata_errs, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/flash_load_seq.md
FLASH_LOAD_SEQ -- requirements
Module: flash_load_seq

Interface
REQ-001 Parameter NBYTES, default 448: bytes loaded, programmed and read back per run (1..512).
REQ-002 Parameter ERASE_WAIT, default 24'd2000000: FASTCLK cycles idled after the Erase command is acknowledged.
REQ-003 Parameter PRG_WAIT, default 24'd500000: FASTCLK cycles idled after the Program command is acknowledged.
REQ-004 Parameter DTACK_TMO, default 16'd1024: maximum FASTCLK cycles to wait for each DTACK edge.
REQ-005 FASTCLK  in  1  sole clock; all state changes on its rising edge.
REQ-006 RST_B  in  1  asynchronous, active-low reset.
REQ-007 START  in  1  one-cycle run request; accepted only in IDLE.
REQ-008 ABORT  in  1  level; ends the run cleanly (see REQ-022).
REQ-009 SRC_DATA  in  8  pattern byte from the host buffer.
REQ-010 SRC_VLD  in  1  SRC_DATA valid.
REQ-011 SRC_RDY  out  1  one-cycle pop; a byte transfers when SRC_VLD & SRC_RDY.
REQ-012 DEVICE  out  1  flash-controller select.
REQ-013 COMMAND  out  10  flash command code: 0 init, 1 load, 2 program, 5 erase, 6 read flash.
REQ-014 STROBE  out  1  command strobe.
REQ-015 WRITE_B  out  1  0 for the write commands (0, 1, 2, 5); 1 for read (6).
REQ-016 INDATA  out  16  {8'h00, byte} during load; 16'h0000 otherwise.
REQ-017 DTACK_B  in  1  active-low acknowledge; a value other than 0 (1, Z or X) reads as 1.
REQ-018 OUTDATA  in  16  read data; bits [7:0] are used.
REQ-019 BUSY, DONE, ERR  out  1 each  status outputs.
REQ-020 ERRCODE  out  2  error cause: 01 DTACK timeout, 10 checksum mismatch.
REQ-021 CHK_WR, CHK_RD  out  16 each  running sums of the loaded bytes and of the read-back bytes.

Function
REQ-022 State sequence: IDLE -> INIT -> ERASE -> ERWAIT -> LOAD (NBYTES times) -> PROG -> PRWAIT -> INIT2 -> READ (NBYTES times) -> CHECK -> IDLE.
- ABORT sampled high in any state other than IDLE: the current handshake completes, then the block returns to IDLE.
- On that return: DONE=0 and ERR=0.
REQ-023 Command handshake, every command state:
- Cycle 0: DEVICE, COMMAND, WRITE_B and INDATA are driven.
- Cycle 1: STROBE goes to 1.
- STROBE is held until DTACK_B==0 is sampled.
- STROBE and DEVICE go to 0 on the next cycle.
- The next command is not started until DTACK_B==1 has been sampled.
REQ-024 Timeout: if either wait (DTACK_B==0, or DTACK_B==1 afterwards) reaches DTACK_TMO cycles:
- STROBE=0 and DEVICE=0;
- ERR=1 and ERRCODE=01;
- the block returns to IDLE.
REQ-025 LOAD, per byte:
- Wait, with no timeout, for SRC_VLD.
- Pulse SRC_RDY for one cycle.
- Latch SRC_DATA onto INDATA[7:0].
- Add the byte to CHK_WR, modulo 2^16.
- Issue command 1.
REQ-026 LOAD byte counter: 10-bit; exits to PROG after byte NBYTES has been acknowledged.
REQ-027 ERWAIT and PRWAIT: a 24-bit counter starts at 0 and counts up; exit occurs on the cycle the counter equals the parameter value minus 1.
REQ-028 INIT2 issues command 0, which resets the read pointer of the downstream flash controller.
REQ-029 READ, per byte:
- Issue command 6 with WRITE_B=1.
- In the cycle DTACK_B==0 is first sampled, capture OUTDATA[7:0] and add it to CHK_RD, modulo 2^16.
REQ-030 READ ends after NBYTES bytes.
REQ-031 CHECK, one cycle:
- CHK_RD==CHK_WR: DONE=1.
- Otherwise: ERR=1 and ERRCODE=10.
REQ-032 Start of a run: START accepted in IDLE clears DONE, ERR, ERRCODE, CHK_WR, CHK_RD and both counters in the same cycle; BUSY=1 from the next cycle.
REQ-033 BUSY is 1 in every state except IDLE.
REQ-034 START while BUSY is ignored.
REQ-035 DONE and ERR hold until the next accepted START, or until reset.
REQ-036 DONE and ERR are never 1 at the same time.
REQ-037 START and ABORT high in the same cycle while in IDLE: the run does not start.
REQ-038 Only one command is outstanding at a time; STROBE is never 1 in IDLE, ERWAIT, PRWAIT or CHECK.

Reset
REQ-039 RST_B low forces, at once and without waiting for FASTCLK:
- state IDLE;
- STROBE=0, DEVICE=0, WRITE_B=1, COMMAND=0, INDATA=0, SRC_RDY=0;
- BUSY=0, DONE=0, ERR=0, ERRCODE=00, CHK_WR=0, CHK_RD=0;
- all counters 0.
REQ-040 Reset during a handshake drops STROBE immediately; no recovery command is issued.
REQ-041 Release of RST_B is synchronous: the first state change occurs on the first FASTCLK edge at which RST_B is high.

Verification
REQ-042 Nominal run: NBYTES=4; ERASE_WAIT=PRG_WAIT=8; source bytes 01 02 03 04; DTACK model acknowledges after 3 cycles and echoes the bytes on read.
- Command order: 0, 5, 1, 1, 1, 1, 2, 0, 6, 6, 6, 6.
- Result: CHK_WR=CHK_RD=16'h000A, DONE=1, ERR=0.
REQ-043 Readback corruption: as REQ-042, but the third read returns 8'hFF.
- Result: CHK_RD=16'h0106, ERR=1, ERRCODE=10, DONE=0.
REQ-044 DTACK timeout: DTACK_TMO=16; the model never acknowledges the Erase command.
- STROBE falls exactly 16 cycles after it rose.
- Result: ERR=1, ERRCODE=01, BUSY=0, and no further STROBE.
REQ-045 Stalled source: SRC_VLD held low for 500 cycles during LOAD, NBYTES=4.
- SRC_RDY, STROBE and DEVICE stay 0 and no timeout occurs.
- The run completes normally once SRC_VLD rises.
REQ-046 ABORT mid-load: ABORT asserted while STROBE is high for the second load command.
- The handshake completes.
- Then BUSY=0, DONE=0 and ERR=0, with no Program command issued.
REQ-047 Reset mid-erase-wait: RST_B pulled low in ERWAIT.
- All outputs take the values of REQ-039 with no clock edge required.
- A new START after release runs the full sequence from INIT.
